// File: rtl/instruction_decode_stage_pkg.sv
// Shared core types: funct fields, ALU operand mode and RV32I major opcodes.
// Also carries the decoded-instruction bundle passed from decoder to stage register.
package instruction_decode_stage_pkg;

  typedef logic [2:0] Funct3_t;
  typedef logic [6:0] Funct7_t;

  // Encoding 0 is REGISTER so a cleared register reads as the register-operand mode.
  typedef enum logic {
    AluRegister = 1'b0,
    AluOpImm    = 1'b1
  } ALUMode_t;

  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcMiscMem = 7'b0001111;
  localparam logic [6:0] OpcSystem  = 7'b1110011;

  localparam Funct7_t Funct7Base = 7'b0000000;
  localparam Funct7_t Funct7Alt  = 7'b0100000;

  typedef struct packed {
    logic [6:0]  opcode;
    Funct3_t     funct3;
    Funct7_t     funct7;
    ALUMode_t    alu_mode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        illegal;
  } decode_t;

endpackage

// File: rtl/instruction_decoder.sv
// Purely combinational RV32I field extraction, immediate generation and
// illegal-encoding detection.
module instruction_decoder
  import instruction_decode_stage_pkg::*;
(
  input  logic [31:0] instruction_i,
  output decode_t     decode_o
);

  logic [6:0] opc;
  Funct3_t    f3;
  Funct7_t    f7;

  assign opc = instruction_i[6:0];
  assign f3  = instruction_i[14:12];
  assign f7  = instruction_i[31:25];

  always_comb begin
    decode_o          = '0;
    decode_o.opcode   = opc;
    decode_o.funct3   = f3;
    decode_o.funct7   = f7;
    decode_o.alu_mode = (opc == OpcOpImm) ? AluOpImm : AluRegister;
    decode_o.rs1      = instruction_i[19:15];
    decode_o.rs2      = instruction_i[24:20];
    decode_o.rd       = instruction_i[11:7];
    decode_o.imm_i    = {{20{instruction_i[31]}}, instruction_i[31:20]};
    decode_o.imm_s    = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
    decode_o.imm_b    = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                         instruction_i[30:25], instruction_i[11:8], 1'b0};
    decode_o.imm_u    = {instruction_i[31:12], 12'b0};
    decode_o.imm_j    = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                         instruction_i[20], instruction_i[30:21], 1'b0};

    case (opc)
      OpcLui, OpcAuipc, OpcJal, OpcMiscMem, OpcSystem: decode_o.illegal = 1'b0;
      OpcJalr:   decode_o.illegal = (f3 != 3'b000);
      OpcBranch: decode_o.illegal = (f3 == 3'b010) || (f3 == 3'b011);
      OpcLoad:   decode_o.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      OpcStore:  decode_o.illegal = (f3 >= 3'b011);
      OpcOpImm: begin
        if (f3 == 3'b001) begin
          decode_o.illegal = (f7 != Funct7Base);
        end else if (f3 == 3'b101) begin
          decode_o.illegal = (f7 != Funct7Base) && (f7 != Funct7Alt);
        end else begin
          decode_o.illegal = 1'b0;
        end
      end
      OpcOp: begin
        // Alternate funct7 only selects SUB (000) and SRA (101).
        decode_o.illegal = !((f7 == Funct7Base) ||
                             ((f7 == Funct7Alt) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      default: decode_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// Decode pipeline stage: one output register behind a valid/ready handshake,
// with flush for redirects and synchronous reset.
module instruction_decode_stage
  import instruction_decode_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] instruction,
  input  logic [31:0] pcIn,
  input  logic        inValid,
  output logic        inReady,
  output logic        outValid,
  input  logic        outReady,
  output logic [6:0]  opcode,
  output Funct3_t     funct3,
  output Funct7_t     funct7,
  output ALUMode_t    aluMode,
  output logic [4:0]  rs1Addr,
  output logic [4:0]  rs2Addr,
  output logic [4:0]  rdAddr,
  output logic [31:0] immediateI,
  output logic [31:0] immediateS,
  output logic [31:0] immediateB,
  output logic [31:0] immediateU,
  output logic [31:0] immediateJ,
  output logic [31:0] pcOut,
  output logic        illegal
);

  decode_t     dec;
  decode_t     dec_d, dec_q;
  logic [31:0] pc_d, pc_q;
  logic        out_valid_d, out_valid_q;
  logic        accept;

  instruction_decoder u_decoder (
    .instruction_i (instruction),
    .decode_o      (dec)
  );

  assign inReady = (!out_valid_q || outReady) && !reset;
  assign accept  = inValid && inReady && !flush;

  always_comb begin
    dec_d       = dec_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      dec_d       = dec;
      pc_d        = pcIn;
      out_valid_d = 1'b1;
    end else if (outReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dec_q       <= '0;
      pc_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dec_q       <= dec_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign outValid   = out_valid_q;
  assign opcode     = dec_q.opcode;
  assign funct3     = dec_q.funct3;
  assign funct7     = dec_q.funct7;
  assign aluMode    = dec_q.alu_mode;
  assign rs1Addr    = dec_q.rs1;
  assign rs2Addr    = dec_q.rs2;
  assign rdAddr     = dec_q.rd;
  assign immediateI = dec_q.imm_i;
  assign immediateS = dec_q.imm_s;
  assign immediateB = dec_q.imm_b;
  assign immediateU = dec_q.imm_u;
  assign immediateJ = dec_q.imm_j;
  assign pcOut      = pc_q;
  assign illegal    = dec_q.illegal;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed self-checking bench for instruction_decode_stage using hand-computed vectors.
module tb_instruction_decode_stage;
  import instruction_decode_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset, flush, inValid, outReady;
  logic [31:0] instruction, pcIn;
  logic        inReady, outValid, illegal;
  logic [6:0]  opcode;
  Funct3_t     funct3;
  Funct7_t     funct7;
  ALUMode_t    aluMode;
  logic [4:0]  rs1Addr, rs2Addr, rdAddr;
  logic [31:0] immediateI, immediateS, immediateB, immediateU, immediateJ, pcOut;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  instruction_decode_stage dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .instruction(instruction),
    .pcIn       (pcIn),
    .inValid    (inValid),
    .inReady    (inReady),
    .outValid   (outValid),
    .outReady   (outReady),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .aluMode    (aluMode),
    .rs1Addr    (rs1Addr),
    .rs2Addr    (rs2Addr),
    .rdAddr     (rdAddr),
    .immediateI (immediateI),
    .immediateS (immediateS),
    .immediateB (immediateB),
    .immediateU (immediateU),
    .immediateJ (immediateJ),
    .pcOut      (pcOut),
    .illegal    (illegal)
  );

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                       input logic rdy);
    instruction = ins;
    pcIn        = pc;
    inValid     = v;
    outReady    = rdy;
  endtask

  task automatic test_reset();
    drive(32'hFFF10093, 32'h0000_0040, 1'b1, 1'b1);
    reset = 1'b0;
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (outValid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_preload outValid got %b want 1", outValid);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (inReady !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_inready got %b want 0", inReady);
    end
    step();
    reset = 1'b0;
    #1;
    vectors++;
    if (outValid !== 1'b0 || illegal !== 1'b0 || immediateI !== 32'h0 || pcOut !== 32'h0 ||
        aluMode !== AluRegister || opcode !== 7'h0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b ill=%b immI=%h pc=%h mode=%b opc=%h want 0s",
               outValid, illegal, immediateI, pcOut, aluMode, opcode);
    end
    vectors++;
    if (inReady !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_inready got %b want 1", inReady);
    end
  endtask

  task automatic test_addi();
    drive(32'hFFF10093, 32'h0000_1000, 1'b1, 1'b1);
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b1);
    vectors++;
    if (outValid !== 1'b1 || opcode !== 7'b0010011 || funct3 !== 3'b000 ||
        aluMode !== AluOpImm || rs1Addr !== 5'd2 || rdAddr !== 5'd1 ||
        immediateI !== 32'hFFFF_FFFF || illegal !== 1'b0 || pcOut !== 32'h0000_1000) begin
      miscompares++;
      $display("FAIL addi got v=%b opc=%b f3=%b mode=%b rs1=%0d rd=%0d immI=%h ill=%b pc=%h",
               outValid, opcode, funct3, aluMode, rs1Addr, rdAddr, immediateI, illegal, pcOut);
    end
    step();
    vectors++;
    if (outValid !== 1'b0 || immediateI !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL drain got v=%b immI=%h want v=0 immI=ffffffff", outValid, immediateI);
    end
  endtask

  task automatic test_sub();
    drive(32'h402081B3, 32'h0000_1004, 1'b1, 1'b1);
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b1);
    vectors++;
    if (funct7 !== 7'b0100000 || aluMode !== AluRegister || rs1Addr !== 5'd1 ||
        rs2Addr !== 5'd2 || rdAddr !== 5'd3 || illegal !== 1'b0 || outValid !== 1'b1) begin
      miscompares++;
      $display("FAIL sub got f7=%b mode=%b rs1=%0d rs2=%0d rd=%0d ill=%b v=%b",
               funct7, aluMode, rs1Addr, rs2Addr, rdAddr, illegal, outValid);
    end
    step();
  endtask

  task automatic test_immediates();
    logic [31:0] ins [4];
    logic [31:0] exp [4];
    ins[0] = 32'h12345037; exp[0] = 32'h12345000;  // lui: U
    ins[1] = 32'hFE20AE23; exp[1] = 32'hFFFF_FFFC;  // sw x2,-4(x1): S
    ins[2] = 32'hFE000EE3; exp[2] = 32'hFFFF_FFFC;  // beq -4: B
    ins[3] = 32'hFFDFF06F; exp[3] = 32'hFFFF_FFFC;  // jal -4: J
    for (int i = 0; i < 4; i++) begin
      logic [31:0] got;
      drive(ins[i], 32'h2000 + 32'(i * 4), 1'b1, 1'b1);
      step();
      case (i)
        0:       got = immediateU;
        1:       got = immediateS;
        2:       got = immediateB;
        default: got = immediateJ;
      endcase
      vectors++;
      if (got !== exp[i] || illegal !== 1'b0) begin
        miscompares++;
        $display("FAIL imm[%0d] got %h ill=%b want %h ill=0", i, got, illegal, exp[i]);
      end
    end
    drive(32'h0, 32'h0, 1'b0, 1'b1);
    step();
  endtask

  task automatic test_illegal();
    logic [31:0] ins [20];
    logic        exp [20];
    ins[0]  = 32'h00000000; exp[0]  = 1'b1;
    ins[1]  = 32'h00000013; exp[1]  = 1'b0;
    ins[2]  = 32'h402091B3; exp[2]  = 1'b1;  // alt funct7 with sll
    ins[3]  = 32'h4020D1B3; exp[3]  = 1'b0;  // sra
    ins[4]  = 32'h02208133; exp[4]  = 1'b1;  // M-extension funct7
    ins[5]  = 32'h40109093; exp[5]  = 1'b1;  // slli alt funct7
    ins[6]  = 32'h4010D093; exp[6]  = 1'b0;  // srai
    ins[7]  = 32'h00109093; exp[7]  = 1'b0;  // slli
    ins[8]  = 32'h00009067; exp[8]  = 1'b1;  // jalr funct3 001
    ins[9]  = 32'h00008067; exp[9]  = 1'b0;
    ins[10] = 32'h00002063; exp[10] = 1'b1;  // branch funct3 010
    ins[11] = 32'h00000063; exp[11] = 1'b0;
    ins[12] = 32'h00003003; exp[12] = 1'b1;  // load funct3 011
    ins[13] = 32'h00004003; exp[13] = 1'b0;
    ins[14] = 32'h00003023; exp[14] = 1'b1;  // store funct3 011
    ins[15] = 32'h00002023; exp[15] = 1'b0;
    ins[16] = 32'h0000007F; exp[16] = 1'b1;
    ins[17] = 32'h00000073; exp[17] = 1'b0;
    ins[18] = 32'h0000000F; exp[18] = 1'b0;
    ins[19] = 32'h00007003; exp[19] = 1'b1;  // load funct3 111
    for (int i = 0; i < 20; i++) begin
      drive(ins[i], 32'h3000 + 32'(i * 4), 1'b1, 1'b1);
      step();
      vectors++;
      if (outValid !== 1'b1 || illegal !== exp[i]) begin
        miscompares++;
        $display("FAIL illegal[%0d] ins=%h got v=%b ill=%b want v=1 ill=%b",
                 i, ins[i], outValid, illegal, exp[i]);
      end
    end
    drive(32'h0, 32'h0, 1'b0, 1'b1);
    step();
  endtask

  task automatic test_back_to_back();
    drive(32'h00500093, 32'h0000_0100, 1'b1, 1'b1);  // addi x1,x0,5
    step();
    drive(32'h00A00113, 32'h0000_0104, 1'b1, 1'b0);  // addi x2,x0,10
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (inReady !== 1'b0 || outValid !== 1'b1 || pcOut !== 32'h100 ||
          immediateI !== 32'd5 || rdAddr !== 5'd1) begin
        miscompares++;
        $display("FAIL stall[%0d] got rdy=%b v=%b pc=%h immI=%h rd=%0d want 0 1 100 5 1",
                 i, inReady, outValid, pcOut, immediateI, rdAddr);
      end
      step();
    end
    outReady = 1'b1;
    step();
    drive(32'h00F00193, 32'h0000_0108, 1'b1, 1'b1);  // addi x3,x0,15
    vectors++;
    if (outValid !== 1'b1 || pcOut !== 32'h104 || immediateI !== 32'd10) begin
      miscompares++;
      $display("FAIL b2b_first got v=%b pc=%h immI=%h want 1 104 a", outValid, pcOut, immediateI);
    end
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b1);
    vectors++;
    if (outValid !== 1'b1 || pcOut !== 32'h108 || rdAddr !== 5'd3) begin
      miscompares++;
      $display("FAIL b2b_second got v=%b pc=%h rd=%0d want 1 108 3", outValid, pcOut, rdAddr);
    end
    step();
    vectors++;
    if (outValid !== 1'b0 || pcOut !== 32'h108) begin
      miscompares++;
      $display("FAIL b2b_drain got v=%b pc=%h want 0 108", outValid, pcOut);
    end
  endtask

  task automatic test_flush();
    drive(32'h00500093, 32'h0000_0200, 1'b1, 1'b1);
    step();
    drive(32'h00A00113, 32'h0000_0204, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      miscompares++;
      $display("FAIL flush got v=%b rdy=%b want v=0 rdy=1", outValid, inReady);
    end
    step();
    vectors++;
    if (outValid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_dropped got v=%b want 0", outValid);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(32'h00500093, 32'h0000_0300, 1'b1, 1'b1);
    step();
    drive(32'h00A00113, 32'h0000_0304, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    #1;
    vectors++;
    if (inReady !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_reset_inready got %b want 0", inReady);
    end
    step();
    reset = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    vectors++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || pcOut !== 32'h0 || rdAddr !== 5'd0) begin
      miscompares++;
      $display("FAIL stall_reset got v=%b rdy=%b pc=%h rd=%0d want 0 1 0 0",
               outValid, inReady, pcOut, rdAddr);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    test_reset();
    test_addi();
    test_sub();
    test_immediates();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
